// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source edges, masks and prioritises them (lowest index wins),
// and drives a clean HOLD-cycle pulse on irq with an EOI handshake before the next one.
module irq_ctrl #(
   parameter int unsigned NSRC = 8,
   parameter int unsigned HOLD = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   input  logic            sel,
   input  logic [1:0]      adr,
   input  logic            rd,
   input  logic            wr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            irq,
   output logic            busy
);

   localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2,
      GAP     = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] enab;
   logic [3:0]      cur;
   logic            claimed;

   logic [NSRC-1:0] src_edge;
   logic [NSRC-1:0] act;
   logic [NSRC-1:0] w1c;
   logic [NSRC-1:0] claim_clr;
   logic [3:0]      idx;
   logic            valid;
   logic            rd_claim;
   logic            wr_pend;
   logic            wr_enab;
   logic            wr_eoi;
   logic            unused_wdata;

   assign unused_wdata = ^wdata[31:NSRC];

   assign wr_pend  = sel & wr & (adr == 2'd0);
   assign wr_enab  = sel & wr & (adr == 2'd1);
   assign wr_eoi   = sel & wr & (adr == 2'd3) & (state == SERVICE);
   assign rd_claim = sel & rd & (adr == 2'd2) & valid;

   // Edge detect and lowest-index priority pick
   always_comb begin
      src_edge = src & ~src_q;
      act      = pend & enab;
      valid    = |act;
      idx      = 4'd0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (act[i]) idx = 4'(i);
      end
      w1c       = wr_pend ? wdata[NSRC-1:0] : '0;
      claim_clr = rd_claim ? (NSRC'(1) << idx) : '0;
   end

   // Register read mux; side effects happen at the clock edge
   always_comb begin
      rdata = 32'd0;
      if (sel) begin
         case (adr)
            2'd0:    rdata = 32'(pend);
            2'd1:    rdata = 32'(enab);
            2'd2:    rdata = valid ? {1'b1, 27'd0, idx} : 32'd0;
            default: rdata = {24'd0, claimed, cur, 1'b0, state};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q   <= '0;
         pend    <= '0;
         enab    <= '0;
         cur     <= 4'd0;
         claimed <= 1'b0;
         state   <= IDLE;
         cnt     <= '0;
         irq     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         src_q <= src;
         // A new edge beats a same-cycle clear
         pend  <= (pend & ~w1c & ~claim_clr) | src_edge;
         if (wr_enab) enab <= wdata[NSRC-1:0];
         if (wr_eoi) claimed <= 1'b0;
         if (rd_claim) begin
            cur     <= idx;
            claimed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (valid) begin
                  state <= ASSERT;
                  cnt   <= CW'(HOLD - 1);
                  irq   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ASSERT: begin
               if (cnt == '0) begin
                  state <= SERVICE;
                  irq   <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            SERVICE: begin
               if (wr_eoi) state <= GAP;
            end
            default: begin
               // GAP guarantees a low cycle before the next rising edge
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: each register read queues its expected rdata/irq/busy,
// and a negedge monitor pops and compares whenever a read is presented.
module tb_irq_ctrl;

   localparam int unsigned NSRC = 8;
   localparam int unsigned HOLD = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] src;
   logic            sel;
   logic [1:0]      adr;
   logic            rd;
   logic            wr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            irq;
   logic            busy;

   logic [NSRC-1:0] srcv;

   typedef struct packed {
      logic [31:0] rdata;
      logic        irq;
      logic        busy;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks   = 0;
   int    failures = 0;

   irq_ctrl #(.NSRC(NSRC), .HOLD(HOLD)) dut (
      .clk   (clk),
      .rst   (rst),
      .src   (src),
      .sel   (sel),
      .adr   (adr),
      .rd    (rd),
      .wr    (wr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Monitor: compare every presented read against the oldest queued expectation
   always @(negedge clk) begin
      if (sel && rd) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read: adr=%0d rdata=%h with no queued expectation", adr, rdata);
         end else begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (rdata !== e.rdata || irq !== e.irq || busy !== e.busy) begin
               failures++;
               $display("FAIL %s: got rdata=%h irq=%b busy=%b, required rdata=%h irq=%b busy=%b",
                        n, rdata, irq, busy, e.rdata, e.irq, e.busy);
            end
         end
      end
   end

   task automatic cyc(input logic s, input logic r, input logic w,
                      input logic [1:0] a, input logic [31:0] d);
      sel   = s;
      rd    = r;
      wr    = w;
      adr   = a;
      wdata = d;
      src   = srcv;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] er, input logic ei, input logic eb, input string n);
      exp_t e;
      e.rdata = er;
      e.irq   = ei;
      e.busy  = eb;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] er,
                         input logic ei, input logic eb, input string n);
      push_exp(er, ei, eb, n);
      cyc(1'b1, 1'b1, 1'b0, a, 32'd0);
   endtask

   task automatic rw_chk(input logic [1:0] a, input logic [31:0] d, input logic [31:0] er,
                         input logic ei, input logic eb, input string n);
      push_exp(er, ei, eb, n);
      cyc(1'b1, 1'b1, 1'b1, a, d);
   endtask

   task automatic wr_only(input logic [1:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      srcv  = '0;
      src   = '0;
      sel   = 1'b0;
      rd    = 1'b0;
      wr    = 1'b0;
      adr   = 2'd0;
      wdata = 32'd0;
      @(posedge clk);
      #1;
      idle_cyc();
      idle_cyc();
      rst = 1'b0;

      // Reset state
      rd_chk(2'd0, 32'h0, 1'b0, 1'b0, "reset_pend");
      rd_chk(2'd1, 32'h0, 1'b0, 1'b0, "reset_enab");
      rd_chk(2'd3, 32'h0, 1'b0, 1'b0, "reset_status");

      // Single source latency and HOLD-cycle pulse
      wr_only(2'd1, 32'h05);
      rd_chk(2'd1, 32'h05, 1'b0, 1'b0, "enab_rb");
      srcv = 8'h04;
      rd_chk(2'd3, 32'h0, 1'b0, 1'b0, "t1_src_cycle");
      srcv = 8'h00;
      rd_chk(2'd0, 32'h04, 1'b0, 1'b0, "t1_pend");
      rd_chk(2'd3, 32'h01, 1'b1, 1'b1, "t1_assert0");
      rd_chk(2'd3, 32'h01, 1'b1, 1'b1, "t1_assert1");
      rd_chk(2'd3, 32'h02, 1'b0, 1'b1, "t1_service");

      // Priority claims
      srcv = 8'h05;
      rd_chk(2'd3, 32'h02, 1'b0, 1'b1, "t2_src_cycle");
      srcv = 8'h00;
      rd_chk(2'd2, 32'h8000_0000, 1'b0, 1'b1, "t2_claim0");
      rd_chk(2'd2, 32'h8000_0002, 1'b0, 1'b1, "t2_claim2");
      rd_chk(2'd2, 32'h0, 1'b0, 1'b1, "t2_claim_empty");
      rd_chk(2'd0, 32'h0, 1'b0, 1'b1, "t2_pend_empty");
      rd_chk(2'd3, 32'h92, 1'b0, 1'b1, "t2_status");

      // EOI with a queued request: GAP, IDLE, then a new pulse
      srcv = 8'h04;
      rd_chk(2'd3, 32'h92, 1'b0, 1'b1, "t3_src_cycle");
      srcv = 8'h00;
      rw_chk(2'd3, 32'h0, 32'h92, 1'b0, 1'b1, "t3_eoi_rdwr");
      rd_chk(2'd3, 32'h13, 1'b0, 1'b1, "t3_gap");
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t3_idle");
      rd_chk(2'd3, 32'h11, 1'b1, 1'b1, "t3_assert0");
      rd_chk(2'd3, 32'h11, 1'b1, 1'b1, "t3_assert1");
      rd_chk(2'd3, 32'h12, 1'b0, 1'b1, "t3_service");
      rd_chk(2'd2, 32'h8000_0002, 1'b0, 1'b1, "t3_claim");
      wr_only(2'd3, 32'h0);
      rd_chk(2'd3, 32'h13, 1'b0, 1'b1, "t3_gap2");
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t3_idle2");

      // Masked source, then late enable; clearing enab mid-pulse
      wr_only(2'd1, 32'h0);
      srcv = 8'h08;
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t4_src_cycle");
      srcv = 8'h00;
      rd_chk(2'd0, 32'h08, 1'b0, 1'b0, "t4_pend_masked");
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t4_no_irq");
      wr_only(2'd1, 32'h08);
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t4_idle_after_enab");
      rd_chk(2'd3, 32'h11, 1'b1, 1'b1, "t4_assert0");
      rw_chk(2'd1, 32'h0, 32'h08, 1'b1, 1'b1, "t4_assert1_enab_clear");
      rd_chk(2'd3, 32'h12, 1'b0, 1'b1, "t4_service");
      rd_chk(2'd2, 32'h0, 1'b0, 1'b1, "t4_claim_masked");
      wr_only(2'd3, 32'h0);
      rd_chk(2'd3, 32'h13, 1'b0, 1'b1, "t4_gap");
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t4_idle");

      // W1C racing a new edge; EOI in IDLE ignored
      srcv = 8'h02;
      rw_chk(2'd0, 32'h0A, 32'h08, 1'b0, 1'b0, "t5_w1c_rdwr");
      srcv = 8'h00;
      rd_chk(2'd0, 32'h02, 1'b0, 1'b0, "t5_pend_set_wins");
      rw_chk(2'd3, 32'h0, 32'h10, 1'b0, 1'b0, "t5_eoi_idle_rdwr");
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t5_eoi_idle_after");

      // Reset mid-service
      srcv = 8'hFF;
      wr_only(2'd1, 32'hFF);
      rd_chk(2'd3, 32'h10, 1'b0, 1'b0, "t6_idle");
      rd_chk(2'd3, 32'h11, 1'b1, 1'b1, "t6_assert0");
      rd_chk(2'd3, 32'h11, 1'b1, 1'b1, "t6_assert1");
      rd_chk(2'd0, 32'hFF, 1'b0, 1'b1, "t6_pend_service");
      rst = 1'b1;
      idle_cyc();
      rst = 1'b0;
      rd_chk(2'd0, 32'h0, 1'b0, 1'b0, "t6_pend_after_rst");
      rd_chk(2'd1, 32'h0, 1'b0, 1'b0, "t6_enab_after_rst");
      rd_chk(2'd3, 32'h0, 1'b0, 1'b0, "t6_status_after_rst");
      rd_chk(2'd0, 32'hFF, 1'b0, 1'b0, "t6_first_cycle_edge");
      idle_cyc();

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
